bios_port_arbiter: RTL and testbench

Two-master arbiter that shares one synchronous memory port (the bootloader RAM's port B: 1-cycle registered read, write-first) between the CPU data bus (master 0) and the debug/loader engine (master 1). It grants at most one access per cycle using round-robin, and routes each response back to its issuer. It also gives master 1 an exclusive lock mode for bulk reprogramming. It sits between the bus interconnect/loader and the memory's port-B inputs.

---
 rtl/bios_port_arbiter_if.sv | 43 ++++
 rtl/bios_port_arbiter.sv | 126 ++++++++++++
 tb/tb_bios_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bios_port_arbiter_if.sv
// ============================================================================
// Module      : bios_port_arbiter_if
// Description : Two-master request/response bundle plus memory port-B wires.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bios_port_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    localparam int c_BE = DATA_WIDTH / 8;

    logic                  req0,    req1;
    logic [ADDR_WIDTH-1:0] addr0,   addr1;
    logic [DATA_WIDTH-1:0] din0,    din1;
    logic [c_BE-1:0]       we0,     we1;
    logic                  gnt0,    gnt1;
    logic                  rvalid0, rvalid1;
    logic [DATA_WIDTH-1:0] rdata0,  rdata1;
    logic                  lock_req;
    logic                  lock_ack;

    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [c_BE-1:0]       mem_we;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport master (
        output req0, req1, addr0, addr1, din0, din1, we0, we1, lock_req,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, lock_ack
    );

    modport slave (
        input  req0, req1, addr0, addr1, din0, din1, we0, we1, lock_req,
        input  mem_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, lock_ack,
        output mem_en, mem_addr, mem_din, mem_we
    );
endinterface

`default_nettype wire

// File: rtl/bios_port_arbiter.sv
// ============================================================================
// Module      : bios_port_arbiter
// Description : Round-robin arbiter sharing the bootloader RAM port B between
//               the CPU data bus and the loader, with a loader lock mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bios_port_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    bios_port_arbiter_if.slave bus
);
    localparam int c_BE = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_OPEN   = 2'd0,
        S_DRAIN  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t r_state;
    logic   r_last;
    logic   r_tag_valid;
    logic   r_tag_master;
    logic   r_lock_ack;

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_elig0;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_din;
    logic [c_BE-1:0]       w_we;
    logic                  w_rvalid0;
    logic                  w_rvalid1;

    // Master 0 is shut out as soon as lock_req is seen, so its last response
    // lands no later than the cycle lock_req rose.
    assign w_elig0 = bus.req0 && !bus.lock_req;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            case (r_state)
                S_OPEN: begin
                    if (w_elig0 && bus.req1) begin
                        w_gnt0 = r_last;
                        w_gnt1 = !r_last;
                    end else if (w_elig0) begin
                        w_gnt0 = 1'b1;
                    end else if (bus.req1) begin
                        w_gnt1 = 1'b1;
                    end
                end
                default: w_gnt1 = bus.req1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_OPEN;
            r_last       <= 1'b1;
            r_tag_valid  <= 1'b0;
            r_tag_master <= 1'b0;
            r_lock_ack   <= 1'b0;
        end else begin
            if (w_gnt0 || w_gnt1) begin
                r_last <= w_gnt1;
            end
            r_tag_valid  <= w_gnt0 || w_gnt1;
            r_tag_master <= w_gnt1;
            case (r_state)
                S_OPEN: begin
                    if (bus.lock_req) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (bus.lock_req) begin
                        r_state    <= S_LOCKED;
                        r_lock_ack <= 1'b1;
                    end else begin
                        r_state <= S_OPEN;
                    end
                end
                S_LOCKED: begin
                    if (!bus.lock_req) begin
                        r_state    <= S_OPEN;
                        r_lock_ack <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_OPEN;
                    r_lock_ack <= 1'b0;
                end
            endcase
        end
    end

    assign w_addr = w_gnt1 ? bus.addr1 : bus.addr0;
    assign w_din  = w_gnt1 ? bus.din1  : bus.din0;
    assign w_we   = w_gnt1 ? bus.we1   : (w_gnt0 ? bus.we0 : {c_BE{1'b0}});

    assign w_rvalid0 = r_tag_valid && !r_tag_master;
    assign w_rvalid1 = r_tag_valid &&  r_tag_master;

    assign bus.gnt0     = w_gnt0;
    assign bus.gnt1     = w_gnt1;
    assign bus.mem_en   = w_gnt0 || w_gnt1;
    assign bus.mem_addr = w_addr;
    assign bus.mem_din  = w_din;
    assign bus.mem_we   = w_we;
    assign bus.rvalid0  = w_rvalid0;
    assign bus.rvalid1  = w_rvalid1;
    assign bus.rdata0   = w_rvalid0 ? bus.mem_dout : {DATA_WIDTH{1'b0}};
    assign bus.rdata1   = w_rvalid1 ? bus.mem_dout : {DATA_WIDTH{1'b0}};
    assign bus.lock_ack = r_lock_ack;

endmodule

`default_nettype wire

// File: tb/tb_bios_port_arbiter.sv
// ============================================================================
// Module      : tb_bios_port_arbiter
// Description : Directed bench for bios_port_arbiter with a write-first RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bios_port_arbiter;
    localparam int c_AW = 12;
    localparam int c_DW = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    bios_port_arbiter_if #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) bus ();

    bios_port_arbiter #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first port B: 1-cycle registered read of the post-write word.
    logic [c_DW-1:0] r_mem [0:(1<<c_AW)-1];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            logic [c_DW-1:0] v;
            v = r_mem[bus.mem_addr];
            for (int b = 0; b < c_DW/8; b++) begin
                if (bus.mem_we[b]) v[b*8 +: 8] = bus.mem_din[b*8 +: 8];
            end
            r_mem[bus.mem_addr] <= v;
            bus.mem_dout        <= v;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock_req = 1'b0;
        bus.addr0 = '0;  bus.addr1 = '0;
        bus.din0  = '0;  bus.din1  = '0;
        bus.we0   = '0;  bus.we1   = '0;
    endtask

    task automatic do_reset();
        step();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic write0(input logic [11:0] a, input logic [31:0] d);
        step();
        bus.req0 = 1'b1; bus.addr0 = a; bus.din0 = d; bus.we0 = 4'hF;
        settle();
        check("preload_gnt0", {31'd0, bus.gnt0}, 32'd1);
        step();
        bus.req0 = 1'b0; bus.we0 = 4'h0;
    endtask

    initial begin
        logic e0, e1, ea, p0, p1;
        n_checks = 0;
        n_errors = 0;
        bus.mem_dout = '0;
        idle_inputs();
        rst = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;

        // Reset state: requests are ignored while rst is high.
        step();
        settle();
        check("rst_gnt0",     {31'd0, bus.gnt0},     32'd0);
        check("rst_gnt1",     {31'd0, bus.gnt1},     32'd0);
        check("rst_rvalid0",  {31'd0, bus.rvalid0},  32'd0);
        check("rst_rvalid1",  {31'd0, bus.rvalid1},  32'd0);
        check("rst_rdata0",   bus.rdata0,            32'd0);
        check("rst_rdata1",   bus.rdata1,            32'd0);
        check("rst_lock_ack", {31'd0, bus.lock_ack}, 32'd0);
        check("rst_mem_en",   {31'd0, bus.mem_en},   32'd0);
        check("rst_mem_we",   {28'd0, bus.mem_we},   32'd0);
        step();
        rst = 1'b0;
        idle_inputs();

        // Single master: write then read back 0x010.
        step();
        bus.req0 = 1'b1; bus.addr0 = 12'h010; bus.din0 = 32'hDEADBEEF; bus.we0 = 4'hF;
        settle();
        check("sm_wr_gnt0",   {31'd0, bus.gnt0},   32'd1);
        check("sm_wr_memwe",  {28'd0, bus.mem_we}, 32'hF);
        step();
        bus.we0 = 4'h0;
        settle();
        check("sm_rd_gnt0",   {31'd0, bus.gnt0},    32'd1);
        check("sm_wr_rvalid", {31'd0, bus.rvalid0}, 32'd1);
        check("sm_wr_rdata",  bus.rdata0,           32'hDEADBEEF);
        check("sm_rvalid1_a", {31'd0, bus.rvalid1}, 32'd0);
        step();
        bus.req0 = 1'b0;
        settle();
        check("sm_idle_gnt0", {31'd0, bus.gnt0},    32'd0);
        check("sm_rd_rvalid", {31'd0, bus.rvalid0}, 32'd1);
        check("sm_rd_rdata",  bus.rdata0,           32'hDEADBEEF);
        check("sm_rvalid1_b", {31'd0, bus.rvalid1}, 32'd0);
        check("sm_memwe_idl", {28'd0, bus.mem_we},  32'd0);
        step();
        settle();
        check("sm_rvalid_end", {31'd0, bus.rvalid0}, 32'd0);

        // Byte enables: master 1 merges bytes 0 and 2 into master 0's word.
        step();
        bus.req0 = 1'b1; bus.addr0 = 12'h020; bus.din0 = 32'h11223344; bus.we0 = 4'hF;
        settle();
        check("be_wr0_gnt0", {31'd0, bus.gnt0}, 32'd1);
        step();
        bus.req0 = 1'b0; bus.we0 = 4'h0;
        bus.req1 = 1'b1; bus.addr1 = 12'h020; bus.din1 = 32'hAABBCCDD; bus.we1 = 4'b0101;
        settle();
        check("be_wr1_gnt1",  {31'd0, bus.gnt1},   32'd1);
        check("be_wr1_memwe", {28'd0, bus.mem_we}, 32'h5);
        check("be_wr0_rdata", bus.rdata0,          32'h11223344);
        step();
        bus.req1 = 1'b0; bus.we1 = 4'h0;
        bus.req0 = 1'b1;
        settle();
        check("be_rd_gnt0",   {31'd0, bus.gnt0},    32'd1);
        check("be_wr1_rv1",   {31'd0, bus.rvalid1}, 32'd1);
        check("be_wr1_rdata", bus.rdata1,           32'h11BB33DD);
        step();
        bus.req0 = 1'b0;
        settle();
        check("be_rd_rv0",   {31'd0, bus.rvalid0}, 32'd1);
        check("be_rd_rdata", bus.rdata0,           32'h11BB33DD);

        write0(12'h100, 32'h0000_1000);
        write0(12'h200, 32'h0000_2000);

        // Contention after reset: 0,1,0,1,0,1 then responses drain.
        do_reset();
        bus.req0 = 1'b1; bus.addr0 = 12'h100;
        bus.req1 = 1'b1; bus.addr1 = 12'h200;
        p0 = 1'b0; p1 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) step();
            if (k == 6) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
            settle();
            e0 = (k < 6) && (k % 2 == 0);
            e1 = (k < 6) && (k % 2 == 1);
            check($sformatf("cont_gnt0_%0d", k),   {31'd0, bus.gnt0},    {31'd0, e0});
            check($sformatf("cont_gnt1_%0d", k),   {31'd0, bus.gnt1},    {31'd0, e1});
            check($sformatf("cont_rv0_%0d", k),    {31'd0, bus.rvalid0}, {31'd0, p0});
            check($sformatf("cont_rv1_%0d", k),    {31'd0, bus.rvalid1}, {31'd0, p1});
            check($sformatf("cont_rd0_%0d", k),    bus.rdata0, p0 ? 32'h1000 : 32'h0);
            check($sformatf("cont_rd1_%0d", k),    bus.rdata1, p1 ? 32'h2000 : 32'h0);
            p0 = e0; p1 = e1;
        end

        // Long lock: lock_req high in cycles 10..19.
        do_reset();
        bus.req0 = 1'b1; bus.addr0 = 12'h100;
        bus.req1 = 1'b1; bus.addr1 = 12'h200;
        p0 = 1'b0; p1 = 1'b0;
        for (int k = 0; k < 24; k++) begin
            if (k > 0) step();
            bus.lock_req = (k >= 10) && (k < 20);
            settle();
            if (k < 10) begin
                e0 = (k % 2 == 0);
            end else if (k >= 21) begin
                e0 = ((k - 21) % 2 == 0);
            end else begin
                e0 = 1'b0;
            end
            e1 = !e0;
            ea = (k >= 12) && (k <= 20);
            check($sformatf("lock_gnt0_%0d", k), {31'd0, bus.gnt0},     {31'd0, e0});
            check($sformatf("lock_gnt1_%0d", k), {31'd0, bus.gnt1},     {31'd0, e1});
            check($sformatf("lock_ack_%0d", k),  {31'd0, bus.lock_ack}, {31'd0, ea});
            check($sformatf("lock_rv0_%0d", k),  {31'd0, bus.rvalid0},  {31'd0, p0});
            check($sformatf("lock_rv1_%0d", k),  {31'd0, bus.rvalid1},  {31'd0, p1});
            p0 = e0; p1 = e1;
        end

        // Short lock pulse: OPEN -> DRAIN -> OPEN, never locked.
        do_reset();
        bus.req0 = 1'b1; bus.addr0 = 12'h100;
        bus.req1 = 1'b1; bus.addr1 = 12'h200;
        settle();
        check("pulse_c0_gnt0", {31'd0, bus.gnt0}, 32'd1);
        step();
        bus.lock_req = 1'b1;
        settle();
        check("pulse_c1_gnt0", {31'd0, bus.gnt0}, 32'd0);
        check("pulse_c1_gnt1", {31'd0, bus.gnt1}, 32'd1);
        step();
        bus.lock_req = 1'b0;
        settle();
        check("pulse_c2_gnt0", {31'd0, bus.gnt0},     32'd0);
        check("pulse_c2_gnt1", {31'd0, bus.gnt1},     32'd1);
        check("pulse_c2_ack",  {31'd0, bus.lock_ack}, 32'd0);
        step();
        settle();
        check("pulse_c3_gnt0", {31'd0, bus.gnt0},     32'd1);
        check("pulse_c3_ack",  {31'd0, bus.lock_ack}, 32'd0);

        // Reset asserted in the cycle of a master-0 read grant.
        step();
        idle_inputs();
        bus.req0 = 1'b1; bus.addr0 = 12'h010;
        settle();
        check("mid_gnt0", {31'd0, bus.gnt0}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_gnt0",   {31'd0, bus.gnt0},   32'd0);
        check("mid_rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        step();
        settle();
        check("mid_rst_rv0",  {31'd0, bus.rvalid0},  32'd0);
        check("mid_rst_rd0",  bus.rdata0,            32'd0);
        check("mid_rst_ack",  {31'd0, bus.lock_ack}, 32'd0);
        check("mid_rst_mwe",  {28'd0, bus.mem_we},   32'd0);
        step();
        rst = 1'b0;
        bus.req1 = 1'b1; bus.addr1 = 12'h200;
        settle();
        check("post_gnt0", {31'd0, bus.gnt0},    32'd1);
        check("post_gnt1", {31'd0, bus.gnt1},    32'd0);
        check("post_rv0",  {31'd0, bus.rvalid0}, 32'd0);
        step();
        settle();
        check("post_gnt1_b", {31'd0, bus.gnt1},    32'd1);
        check("post_rv0_b",  {31'd0, bus.rvalid0}, 32'd1);
        check("post_rd0_b",  bus.rdata0,           32'hDEADBEEF);

        step();
        idle_inputs();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
